sort_ctrl: RTL

SORT_CTRL -- requirements
Module: sort_ctrl

---
 rtl/sorter_pkg.sv | 20 ++
 rtl/sort_cmp_swap.sv | 20 ++
 rtl/sort_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/sorter_pkg.sv
// Shared types and constants for the in-place bubble sorter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: DATA_W (memory word width) and state_e (controller FSM states).
package sorter_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    CMP,
    WR_A,
    WR_B,
    NEXT,
    DONE
  } state_e;

endpackage

// File: rtl/sort_cmp_swap.sv
// Compare-and-order unit: decides whether an adjacent pair must be swapped.
// Latency: combinational.
// Backpressure: none.
// Ports: a_i/b_i words at addresses j/j+1; swap_o=1 when a_i>b_i (unsigned,
//        equal pairs are left alone); lo_o/hi_o the pair in ascending order.
module sort_cmp_swap
  import sorter_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              swap_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [DATA_W-1:0] hi_o
);

  assign swap_o = (a_i > b_i);
  assign lo_o   = swap_o ? b_i : a_i;
  assign hi_o   = swap_o ? a_i : b_i;

endmodule

// File: rtl/sort_ctrl.sv
// Ascending unsigned in-place bubble sort over words 0..SIZE-1 of an external memory.
// Latency: 4 cycles per compare without swap, 6 with swap; SIZE-1 passes
//          (fewer when SORTER_EARLY_EXIT_EN is defined and a pass makes no swap).
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
// Ports: clk, rst_n (async active-low); start in; busy/done/swap_cnt status out;
//        mem_addr/mem_wdata/mem_we/mem_re/mem_en (active-low) memory master,
//        mem_rdata combinational read data.
module sort_ctrl
  import sorter_pkg::*;
#(
  parameter int SIZE   = 8,
  parameter int ADDR_W = $clog2(SIZE) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [15:0]       swap_cnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic              mem_en,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Last pass index; wraps for SIZE=1 but NEXT is never reached then.
  localparam logic [ADDR_W-1:0] LAST_I = ADDR_W'(SIZE - 2);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] j_q, j_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [15:0]       swap_cnt_q, swap_cnt_d;
`ifdef SORTER_EARLY_EXIT_EN
  logic              flag_q, flag_d;
`endif

  logic              do_swap;
  logic [DATA_W-1:0] lo_w, hi_w;
  logic [ADDR_W-1:0] last_j;

  sort_cmp_swap u_cmp (
    .a_i    (a_q),
    .b_i    (b_q),
    .swap_o (do_swap),
    .lo_o   (lo_w),
    .hi_o   (hi_w)
  );

  // Each pass i compares j against j+1 for j = 0 .. SIZE-2-i.
  assign last_j = LAST_I - i_q;

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    a_d        = a_q;
    b_d        = b_q;
    swap_cnt_d = swap_cnt_q;
`ifdef SORTER_EARLY_EXIT_EN
    flag_d     = flag_q;
`endif
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_en     = 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          i_d        = '0;
          j_d        = '0;
          swap_cnt_d = '0;
`ifdef SORTER_EARLY_EXIT_EN
          flag_d     = 1'b0;
`endif
          if (SIZE == 1) state_d = DONE;
          else           state_d = RD_A;
        end
      end
      RD_A: begin
        mem_addr = j_q;
        mem_re   = 1'b1;
        mem_en   = 1'b0;
        a_d      = mem_rdata;
        state_d  = RD_B;
      end
      RD_B: begin
        mem_addr = j_q + ADDR_W'(1);
        mem_re   = 1'b1;
        mem_en   = 1'b0;
        b_d      = mem_rdata;
        state_d  = CMP;
      end
      CMP: begin
        state_d = do_swap ? WR_A : NEXT;
      end
      // WR_A/WR_B are only entered on a swap, so lo=b and hi=a here.
      WR_A: begin
        mem_addr  = j_q;
        mem_wdata = lo_w;
        mem_we    = 1'b1;
        mem_en    = 1'b0;
        state_d   = WR_B;
      end
      WR_B: begin
        mem_addr  = j_q + ADDR_W'(1);
        mem_wdata = hi_w;
        mem_we    = 1'b1;
        mem_en    = 1'b0;
        if (swap_cnt_q != 16'hFFFF) swap_cnt_d = swap_cnt_q + 16'd1;
`ifdef SORTER_EARLY_EXIT_EN
        flag_d    = 1'b1;
`endif
        state_d   = NEXT;
      end
      NEXT: begin
        if (j_q < last_j) begin
          j_d     = j_q + ADDR_W'(1);
          state_d = RD_A;
        end
`ifdef SORTER_EARLY_EXIT_EN
        // A pass without any swap proves the array is already ordered.
        else if (!flag_q) begin
          state_d = DONE;
        end
`endif
        else if (i_q < LAST_I) begin
          i_d     = i_q + ADDR_W'(1);
          j_d     = '0;
`ifdef SORTER_EARLY_EXIT_EN
          flag_d  = 1'b0;
`endif
          state_d = RD_A;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      swap_cnt_q <= '0;
`ifdef SORTER_EARLY_EXIT_EN
      flag_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      a_q        <= a_d;
      b_q        <= b_d;
      swap_cnt_q <= swap_cnt_d;
`ifdef SORTER_EARLY_EXIT_EN
      flag_q     <= flag_d;
`endif
    end
  end

  // Status is decoded straight from the state register so reset clears it at once.
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign swap_cnt = swap_cnt_q;

endmodule
